pll_lock_supervisor: RTL

//  Controller end of the audio PLL interface: drives the PLL areset, watches the PLL locked output and

---
 rtl/pll_lock_supervisor_pkg.sv | 24 ++
 rtl/pll_lock_supervisor_sync_bit.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encodings,
// the retry counter width and a small helper used to size the shared counter.
package pll_lock_supervisor_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Largest of three values; used to size the counter shared by all timed states.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Single-bit multi-flop synchronizer with a synchronous clear.
// Used to bring the asynchronous PLL lock flag into the reference clock domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the input through the chain; clear forces a known "not locked" view.
  always_ff @(posedge clk) begin
    if (clr) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds the PLL in reset, waits for a synchronized lock,
// qualifies it for a stable window, then releases the audio-domain reset.
// Lock timeouts retry the PLL up to MAX_RETRIES times before latching FAIL;
// losing lock in RUN re-sequences from RESET_PLL and sets a sticky flag.
//
// Control interface: rearm is a single-cycle request pulse with no
// acknowledge; it is only acted on in FAIL and ignored in every other state.
// The current FSM state is available on the internal signal "state".
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 7,
  parameter int SYNC_STAGES         = 2
) (
  input  logic               inclk0,
  input  logic               areset,
  input  logic               pll_locked,
  input  logic               rearm,
  output logic               pll_areset,
  output logic               sys_reset,
  output logic               ready,
  output logic               lock_fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  // One counter serves every timed state, so it is sized for the longest dwell.
  localparam int CNT_MAX = max3(PLL_RESET_CYCLES - 1, LOCK_TIMEOUT_CYCLES - 1,
                                LOCK_STABLE_CYCLES - 1);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             retry_inc;
  logic             retry_clr;
  logic             lost_set;
  logic             locked_s;

  // The FSM only ever looks at the synchronized lock flag.
  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (inclk0),
    .clr (areset),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, counter and side-effect decode for the supervisor FSM.
  always_comb begin
    state_n   = state;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    lost_set  = 1'b0;
    case (state)
      ST_RESET_PLL: begin
        if (cnt == RST_LAST) state_n = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_n = ST_QUALIFY;
        end else if (cnt == TO_LAST) begin
          if (retry_count == RETRY_MAX) begin
            state_n = ST_FAIL;
          end else begin
            state_n   = ST_RESET_PLL;
            retry_inc = 1'b1;
          end
        end
      end
      ST_QUALIFY: begin
        // A dropout restarts the lock wait with a fresh timeout but costs no retry.
        if (!locked_s)            state_n = ST_WAIT_LOCK;
        else if (cnt == STB_LAST) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_n  = ST_RESET_PLL;
          lost_set = 1'b1;
        end
      end
      ST_FAIL: begin
        if (rearm) begin
          state_n   = ST_RESET_PLL;
          retry_clr = 1'b1;
        end
      end
      default: state_n = ST_RESET_PLL;
    endcase

    if (state_n == ST_RUN && state != ST_RUN) retry_clr = 1'b1;

    // Counter restarts on every state change; it idles in the untimed states.
    if (state_n != state)                       cnt_n = '0;
    else if (state == ST_RUN || state == ST_FAIL) cnt_n = cnt;
    else                                        cnt_n = cnt + 1'b1;
  end

  // State, counters and outputs; outputs decode the next state so they move with it.
  always_ff @(posedge inclk0) begin
    if (areset) begin
      state       <= ST_RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
      pll_areset  <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (retry_clr)      retry_count <= '0;
      else if (retry_inc) retry_count <= retry_count + 1'b1;
      if (lost_set) lock_lost <= 1'b1;
      pll_areset <= (state_n == ST_RESET_PLL) || (state_n == ST_FAIL);
      sys_reset  <= (state_n != ST_RUN);
      ready      <= (state_n == ST_RUN);
      lock_fail  <= (state_n == ST_FAIL);
    end
  end

endmodule
